// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard/pipeline-control unit: FSM states,
// forwarding selects and Result_Src values.
package hazard_ctrl_pkg;

   typedef logic [1:0] state_t;
   localparam state_t ST_RUN      = 2'd0;
   localparam state_t ST_MEM_WAIT = 2'd1;
   localparam state_t ST_REDIRECT = 2'd2;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam logic [1:0] RES_ALU  = 2'b00;
   localparam logic [1:0] RES_MEM  = 2'b01;
   localparam logic [1:0] RES_PC4  = 2'b10;
   localparam logic [1:0] RES_IMM  = 2'b11;
   localparam logic [1:0] LOAD_SRC = RES_MEM;

endpackage

// File: rtl/hazard_fwd_sel.sv
// EX operand forwarding select for one source register; purely combinational.
// MEM result wins over WB; x0 is never forwarded.
module hazard_fwd_sel
   import hazard_ctrl_pkg::*;
(
   input  logic [4:0] ex_rs_addr_i,
   input  logic [4:0] mem_rd_i,
   input  logic       mem_reg_write_i,
   input  logic [4:0] wb_rd_i,
   input  logic       wb_reg_write_i,
   output logic [1:0] fwd_o
);

   always_comb begin
      fwd_o = FWD_RF;
      if (mem_reg_write_i && (mem_rd_i != 5'd0) && (mem_rd_i == ex_rs_addr_i))
         fwd_o = FWD_MEM;
      else if (wb_reg_write_i && (wb_rd_i != 5'd0) && (wb_rd_i == ex_rs_addr_i))
         fwd_o = FWD_WB;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and pipeline-control unit: stall/flush/hold controls, forwarding selects, perf counters.
// Controls are combinational from state and inputs (zero-cycle latency); memory wait freezes everything.
module hazard_ctrl #(
   parameter int         REDIRECT_BUBBLES = 1,
   parameter int         CNT_W            = 32,
   parameter logic [1:0] LOAD_SRC         = hazard_ctrl_pkg::RES_MEM
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1_addr,
   input  logic [4:0]       id_rs2_addr,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_reg_write,
   input  logic [1:0]       ex_result_src,
   input  logic [4:0]       ex_rs1_addr,
   input  logic [4:0]       ex_rs2_addr,
   input  logic             ex_redirect,
   input  logic [4:0]       mem_rd,
   input  logic             mem_reg_write,
   input  logic [4:0]       wb_rd,
   input  logic             wb_reg_write,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             stall_if,
   output logic             stall_id,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             hold_all,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   import hazard_ctrl_pkg::*;

   localparam logic [2:0]       BUB_RELOAD = 3'(REDIRECT_BUBBLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [2:0]       bub_q, bub_d;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
   logic             lu, mw, run_rules, redirect_evt;
   logic             stall_if_c, stall_id_c, flush_ifid_c, flush_idex_c, hold_all_c;
   logic [1:0]       fwd_a_c, fwd_b_c;

   assign lu = ex_reg_write && (ex_result_src == LOAD_SRC) && (ex_rd != 5'd0) &&
               ((id_uses_rs1 && (id_rs1_addr == ex_rd)) || (id_uses_rs2 && (id_rs2_addr == ex_rd)));
   assign mw = dmem_req && !dmem_ready;

   always_comb begin
      stall_if_c   = 1'b0;
      stall_id_c   = 1'b0;
      flush_ifid_c = 1'b0;
      flush_idex_c = 1'b0;
      hold_all_c   = 1'b0;
      redirect_evt = 1'b0;
      run_rules    = 1'b0;
      state_d      = state_q;
      bub_d        = bub_q;
      case (state_q)
         ST_MEM_WAIT: begin
            if (mw) hold_all_c = 1'b1;
            else    run_rules  = 1'b1;
         end
         ST_REDIRECT: begin
            // A memory wait pauses the bubble count without flushing.
            if (mw) begin
               hold_all_c = 1'b1;
            end else if (ex_redirect) begin
               flush_ifid_c = 1'b1;
               flush_idex_c = 1'b1;
               redirect_evt = 1'b1;
               bub_d        = BUB_RELOAD;
            end else begin
               flush_ifid_c = 1'b1;
               if (bub_q <= 3'd1) begin
                  state_d = ST_RUN;
                  bub_d   = 3'd0;
               end else begin
                  bub_d = bub_q - 3'd1;
               end
            end
         end
         default: run_rules = 1'b1;
      endcase
      // MEM_WAIT releasing on dmem_ready falls through to RUN arbitration in the same cycle.
      if (run_rules) begin
         state_d = ST_RUN;
         if (mw) begin
            hold_all_c = 1'b1;
            state_d    = ST_MEM_WAIT;
         end else if (ex_redirect) begin
            flush_ifid_c = 1'b1;
            flush_idex_c = 1'b1;
            redirect_evt = 1'b1;
            if (REDIRECT_BUBBLES > 1) begin
               state_d = ST_REDIRECT;
               bub_d   = BUB_RELOAD;
            end
         end else if (lu) begin
            stall_if_c   = 1'b1;
            stall_id_c   = 1'b1;
            flush_idex_c = 1'b1;
         end
      end
   end

   hazard_fwd_sel u_fwd_a (
      .ex_rs_addr_i    (ex_rs1_addr),
      .mem_rd_i        (mem_rd),
      .mem_reg_write_i (mem_reg_write),
      .wb_rd_i         (wb_rd),
      .wb_reg_write_i  (wb_reg_write),
      .fwd_o           (fwd_a_c)
   );

   hazard_fwd_sel u_fwd_b (
      .ex_rs_addr_i    (ex_rs2_addr),
      .mem_rd_i        (mem_rd),
      .mem_reg_write_i (mem_reg_write),
      .wb_rd_i         (wb_rd),
      .wb_reg_write_i  (wb_reg_write),
      .fwd_o           (fwd_b_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         bub_q       <= 3'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         bub_q   <= bub_d;
         if ((hold_all_c || stall_id_c) && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_ONE;
         if (redirect_evt && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + CNT_ONE;
      end
   end

   // Reset forces every output low without waiting for a clock edge.
   assign stall_if   = stall_if_c   & ~rst;
   assign stall_id   = stall_id_c   & ~rst;
   assign flush_ifid = flush_ifid_c & ~rst;
   assign flush_idex = flush_idex_c & ~rst;
   assign hold_all   = hold_all_c   & ~rst;
   assign fwd_a      = rst ? FWD_RF : fwd_a_c;
   assign fwd_b      = rst ? FWD_RF : fwd_b_c;
   assign stall_cnt  = stall_cnt_q;
   assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (3 redirect bubbles, 4-bit counters so saturation is reachable).
module tb_hazard_ctrl;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    id_rs1_addr, id_rs2_addr, ex_rd, ex_rs1_addr, ex_rs2_addr, mem_rd, wb_rd;
   logic          id_uses_rs1, id_uses_rs2, ex_reg_write, ex_redirect;
   logic          mem_reg_write, wb_reg_write, dmem_req, dmem_ready;
   logic [1:0]    ex_result_src;
   logic          stall_if, stall_id, flush_ifid, flush_idex, hold_all;
   logic [1:0]    fwd_a, fwd_b;
   logic [CW-1:0] stall_cnt, flush_cnt;

   hazard_ctrl #(.REDIRECT_BUBBLES(3), .CNT_W(CW), .LOAD_SRC(2'b01)) dut (
      .clk(clk), .rst(rst),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_result_src(ex_result_src),
      .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_redirect(ex_redirect),
      .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
      .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .stall_if(stall_if), .stall_id(stall_id), .flush_ifid(flush_ifid),
      .flush_idex(flush_idex), .hold_all(hold_all),
      .fwd_a(fwd_a), .fwd_b(fwd_b),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   // {stall_if, stall_id, flush_ifid, flush_idex, hold_all, fwd_a, fwd_b}
   logic [8:0] obs;
   assign obs = {stall_if, stall_id, flush_ifid, flush_idex, hold_all, fwd_a, fwd_b};

   localparam logic [8:0] E0   = 9'b00000_0000;
   localparam logic [8:0] ELU  = 9'b11010_0000;
   localparam logic [8:0] ERD  = 9'b00110_0000;
   localparam logic [8:0] EFL  = 9'b00100_0000;
   localparam logic [8:0] EHLD = 9'b00001_0000;

   typedef struct packed {
      logic [4:0] id_rs1;
      logic [4:0] id_rs2;
      logic       u1;
      logic       u2;
      logic [4:0] ex_rd;
      logic       ex_wr;
      logic [1:0] ex_src;
      logic       redir;
      logic       req;
      logic       rdy;
   } stim_t;

   typedef struct packed {
      logic [8:0] ctrl;
      logic       redir;
   } exp_t;

   localparam stim_t D    = '0;
   localparam stim_t LU   = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0};
   localparam stim_t RDLU = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0};
   localparam stim_t RD   = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
   localparam stim_t MW   = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0};
   localparam stim_t RDY  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1};
   localparam stim_t MWRD = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0};
   localparam stim_t RYRD = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1};
   localparam stim_t MWLU = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0};
   localparam stim_t RYLU = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1};

   exp_t       exp_q[$];
   logic [3:0] fwd_q[$];
   int         checks = 0;
   int         errors = 0;
   logic [CW-1:0] m_stall = '0;
   logic [CW-1:0] m_flush = '0;

   task automatic apply(input stim_t s);
      id_rs1_addr   = s.id_rs1;
      id_rs2_addr   = s.id_rs2;
      id_uses_rs1   = s.u1;
      id_uses_rs2   = s.u2;
      ex_rd         = s.ex_rd;
      ex_reg_write  = s.ex_wr;
      ex_result_src = s.ex_src;
      ex_redirect   = s.redir;
      dmem_req      = s.req;
      dmem_ready    = s.rdy;
   endtask

   // Counter model: a stall cycle is hold_all or stall_id; a redirect event is flush_idex caused by ex_redirect.
   task automatic model_update(input exp_t x);
      if ((x.ctrl[4] || x.ctrl[7]) && (m_stall != '1)) m_stall = m_stall + 1'b1;
      if (x.ctrl[5] && x.redir && (m_flush != '1)) m_flush = m_flush + 1'b1;
   endtask

   task automatic test_reset();
      apply(LU);
      mem_reg_write = 1'b1; mem_rd = 5'd5; ex_rs1_addr = 5'd5;
      #3;
      checks++;
      if (obs !== E0) begin errors++; $display("FAIL reset_ctrl got %b want %b", obs, E0); end
      checks++;
      if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
         errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt);
      end
      apply(D);
      mem_reg_write = 1'b0; mem_rd = 5'd0; ex_rs1_addr = 5'd0;
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== E0) begin errors++; $display("FAIL idle_ctrl got %b want %b", obs, E0); end
   endtask

   task automatic test_load_use();
      stim_t s[8];
      logic [8:0] e[8];
      exp_t x;
      s = '{LU, D, '{5'd0, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0},
            '{5'd0, 5'd9, 1'b0, 1'b0, 5'd9, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0},
            '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0},
            '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0},
            '{5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0}, D};
      e = '{ELU, E0, ELU, E0, E0, E0, E0, E0};
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1; apply(s[i]); exp_q.push_back('{e[i], s[i].redir});
         @(negedge clk); x = exp_q.pop_front();
         checks++;
         if (obs !== x.ctrl) begin errors++; $display("FAIL load_use[%0d] ctrl got %b want %b", i, obs, x.ctrl); end
         checks++;
         if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
            errors++; $display("FAIL load_use[%0d] cnt got %0d/%0d want %0d/%0d", i, stall_cnt, flush_cnt, m_stall, m_flush);
         end
         model_update(x);
      end
   endtask

   task automatic test_back_to_back();
      stim_t s[3];
      logic [8:0] e[3];
      exp_t x;
      s = '{LU, '{5'd0, 5'd6, 1'b0, 1'b1, 5'd6, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0}, D};
      e = '{ELU, ELU, E0};
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1; apply(s[i]); exp_q.push_back('{e[i], s[i].redir});
         @(negedge clk); x = exp_q.pop_front();
         checks++;
         if (obs !== x.ctrl) begin errors++; $display("FAIL b2b[%0d] ctrl got %b want %b", i, obs, x.ctrl); end
         checks++;
         if (stall_cnt !== m_stall) begin errors++; $display("FAIL b2b[%0d] stall_cnt got %0d want %0d", i, stall_cnt, m_stall); end
         model_update(x);
      end
   endtask

   task automatic test_redirect();
      stim_t s[15];
      logic [8:0] e[15];
      exp_t x;
      // plain redirect with load-use; redirect then memory wait; redirect reload inside REDIRECT
      s = '{RDLU, D, D, D,  RD, MW, MW, RDY, D, D,  RD, RD, D, D, D};
      e = '{ERD, EFL, EFL, E0,  ERD, EHLD, EHLD, EFL, EFL, E0,  ERD, ERD, EFL, EFL, E0};
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1; apply(s[i]); exp_q.push_back('{e[i], s[i].redir});
         @(negedge clk); x = exp_q.pop_front();
         checks++;
         if (obs !== x.ctrl) begin errors++; $display("FAIL redirect[%0d] ctrl got %b want %b", i, obs, x.ctrl); end
         checks++;
         if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
            errors++; $display("FAIL redirect[%0d] cnt got %0d/%0d want %0d/%0d", i, stall_cnt, flush_cnt, m_stall, m_flush);
         end
         model_update(x);
      end
   endtask

   task automatic test_mem_wait();
      stim_t s[15];
      logic [8:0] e[15];
      exp_t x;
      // plain wait; masked redirect released on ready; masked load-use released on ready
      s = '{MW, MW, MW, MW, RDY, D,  MW, MWRD, RYRD, D, D, D,  MWLU, RYLU, D};
      e = '{EHLD, EHLD, EHLD, EHLD, E0, E0,  EHLD, EHLD, ERD, EFL, EFL, E0,  EHLD, ELU, E0};
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1; apply(s[i]); exp_q.push_back('{e[i], s[i].redir});
         @(negedge clk); x = exp_q.pop_front();
         checks++;
         if (obs !== x.ctrl) begin errors++; $display("FAIL mem_wait[%0d] ctrl got %b want %b", i, obs, x.ctrl); end
         checks++;
         if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
            errors++; $display("FAIL mem_wait[%0d] cnt got %0d/%0d want %0d/%0d", i, stall_cnt, flush_cnt, m_stall, m_flush);
         end
         model_update(x);
      end
   endtask

   task automatic test_saturation();
      exp_t x;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1; apply(i < 5 ? MW : RDY); exp_q.push_back('{(i < 5 ? EHLD : E0), 1'b0});
         @(negedge clk); x = exp_q.pop_front();
         checks++;
         if (obs !== x.ctrl) begin errors++; $display("FAIL sat[%0d] ctrl got %b want %b", i, obs, x.ctrl); end
         model_update(x);
      end
      @(posedge clk); #1; apply(D);
      @(negedge clk);
      checks++;
      if (stall_cnt !== m_stall || m_stall !== 4'hF) begin
         errors++; $display("FAIL sat stall_cnt got %0d want %0d (15)", stall_cnt, m_stall);
      end
   endtask

   task automatic test_forwarding();
      logic [4:0] t_rs1[6], t_rs2[6], t_mrd[6], t_wrd[6];
      logic       t_mw[6], t_ww[6];
      logic [3:0] t_exp[6];
      logic [3:0] want;
      t_rs1 = '{5'd7, 5'd0, 5'd7, 5'd7, 5'd3, 5'd9};
      t_rs2 = '{5'd7, 5'd0, 5'd9, 5'd9, 5'd4, 5'd7};
      t_mrd = '{5'd7, 5'd0, 5'd7, 5'd7, 5'd5, 5'd9};
      t_mw  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      t_wrd = '{5'd7, 5'd0, 5'd9, 5'd7, 5'd6, 5'd9};
      t_ww  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      t_exp = '{4'b1010, 4'b0000, 4'b1001, 4'b0100, 4'b0000, 4'b0000};
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         ex_rs1_addr = t_rs1[i]; ex_rs2_addr = t_rs2[i];
         mem_rd = t_mrd[i]; mem_reg_write = t_mw[i];
         wb_rd = t_wrd[i]; wb_reg_write = t_ww[i];
         fwd_q.push_back(t_exp[i]);
         @(negedge clk); want = fwd_q.pop_front();
         checks++;
         if ({fwd_a, fwd_b} !== want) begin
            errors++; $display("FAIL fwd[%0d] got a=%b b=%b want a=%b b=%b", i, fwd_a, fwd_b, want[3:2], want[1:0]);
         end
      end
      @(posedge clk); #1;
      ex_rs1_addr = 5'd0; ex_rs2_addr = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
      mem_reg_write = 1'b0; wb_reg_write = 1'b0;
   endtask

   task automatic test_async_reset();
      @(posedge clk); #1; apply(RD);
      @(posedge clk); #1; apply(LU);
      @(negedge clk);
      checks++;
      if (obs !== EFL || flush_cnt !== m_flush + 1'b1) begin
         errors++; $display("FAIL pre_reset got %b flush_cnt %0d want %b %0d", obs, flush_cnt, EFL, m_flush + 1'b1);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (obs !== E0) begin errors++; $display("FAIL async_reset ctrl got %b want %b", obs, E0); end
      checks++;
      if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
         errors++; $display("FAIL async_reset cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt);
      end
      m_stall = '0; m_flush = '0;
      apply(D);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1; apply(D);
      @(negedge clk);
      checks++;
      if (obs !== E0) begin errors++; $display("FAIL post_reset_run got %b want %b", obs, E0); end
      @(posedge clk); #1; apply(LU);
      @(negedge clk);
      checks++;
      if (obs !== ELU) begin errors++; $display("FAIL post_reset_lu got %b want %b", obs, ELU); end
      @(posedge clk); #1; apply(D);
      @(negedge clk);
      checks++;
      if (stall_cnt !== 4'd1 || flush_cnt !== 4'd0) begin
         errors++; $display("FAIL post_reset_cnt got %0d/%0d want 1/0", stall_cnt, flush_cnt);
      end
   endtask

   initial begin
      rst = 1'b1;
      apply(D);
      ex_rs1_addr = 5'd0; ex_rs2_addr = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
      mem_reg_write = 1'b0; wb_reg_write = 1'b0;
      test_reset();
      test_load_use();
      test_back_to_back();
      test_redirect();
      test_mem_wait();
      test_saturation();
      test_forwarding();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
